// File: rtl/rv32i_fetch_unit_if.sv
// Fetch-stage bundle: imem request/response channel, execute redirect and decode handshake.
// master = fetch unit side, slave = memory/execute/decode side.
interface rv32i_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic        decode_ready;
    logic [31:0] fetch_instruction;
    logic [31:0] fetch_pc;
    logic        fetch_misaligned;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output fetch_valid, fetch_instruction, fetch_pc, fetch_misaligned,
        input  decode_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  fetch_valid, fetch_instruction, fetch_pc, fetch_misaligned,
        output decode_ready
    );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// RV32I fetch stage: PC, credit-limited in-order imem reads, instruction FIFO, redirect flush/drop.
// Optional macro RV32I_FETCH_ALIGN_CHECK_EN: misaligned redirect yields one faulting NOP entry and halts fetch.
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    rv32i_fetch_unit_if.master bus
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = AW + 1;
    localparam int          SW      = CW + 1;
    localparam logic [31:0] NOP_INS = 32'h0000_0013;

    logic          r_run;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_ifq_wr;
    logic [AW-1:0] r_ifq_rd;
    logic [AW-1:0] r_fq_wr;
    logic [AW-1:0] r_fq_rd;
    logic [31:0]   r_ifq_pc   [FIFO_DEPTH];
    logic [31:0]   r_fq_instr [FIFO_DEPTH];
    logic [31:0]   r_fq_pc    [FIFO_DEPTH];

    logic          w_halt;
    logic          w_fault_push;
    logic          w_redir;
    logic          w_credit;
    logic          w_req_valid;
    logic          w_req_acc;
    logic          w_rsp;
    logic          w_rsp_push;
    logic          w_push;
    logic          w_pop;
    logic          w_fetch_valid;
    logic [31:0]   w_redir_pc;
    logic [31:0]   w_push_instr;
    logic [31:0]   w_push_pc;
    logic [CW-1:0] w_outst_nx;
    logic [CW-1:0] w_drop_nx;

    assign w_redir       = bus.redirect_valid;
    assign w_credit      = (SW'(r_outst) + SW'(r_count)) < SW'(FIFO_DEPTH);
    assign w_req_valid   = r_run & w_credit & ~w_redir & ~w_halt;
    assign w_req_acc     = w_req_valid & bus.imem_req_ready;
    assign w_rsp         = bus.imem_rsp_valid;
    assign w_rsp_push    = w_rsp & (r_drop == {CW{1'b0}});
    assign w_fetch_valid = (r_count != {CW{1'b0}});
    assign w_pop         = w_fetch_valid & bus.decode_ready;
    assign w_push        = w_rsp_push | w_fault_push;
    assign w_push_instr  = w_rsp_push ? bus.imem_rsp_data : NOP_INS;
    assign w_push_pc     = w_rsp_push ? r_ifq_pc[r_ifq_rd] : r_pc;
    assign w_outst_nx    = r_outst + CW'(w_req_acc) - CW'(w_rsp);

    // Responses still owed for flushed requests must be discarded; a redirect re-arms with everything in flight
    always_comb begin
        w_drop_nx = r_drop;
        if (w_redir) begin
            w_drop_nx = w_outst_nx;
        end else if (w_rsp && (r_drop != {CW{1'b0}})) begin
            w_drop_nx = r_drop - CW'(1'b1);
        end else begin
            w_drop_nx = r_drop;
        end
    end

`ifdef RV32I_FETCH_ALIGN_CHECK_EN
    logic r_halt;
    logic r_fault_pend;
    logic r_fq_mis [FIFO_DEPTH];
    logic w_misalign;

    assign w_misalign   = (bus.redirect_pc[1:0] != 2'b00);
    assign w_redir_pc   = bus.redirect_pc;
    assign w_halt       = r_halt;
    assign w_fault_push = r_fault_pend & (r_drop == {CW{1'b0}}) & ~w_redir & ~w_rsp;

    // Misaligned target: stop fetching, emit the fault entry once stale responses have drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halt       <= 1'b0;
            r_fault_pend <= 1'b0;
        end else if (w_redir) begin
            r_halt       <= w_misalign;
            r_fault_pend <= w_misalign;
        end else if (w_fault_push) begin
            r_fault_pend <= 1'b0;
        end
    end

    // Fault flag storage alongside the instruction FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_fq_mis[i] <= 1'b0;
        end else if (w_push && !w_redir) begin
            r_fq_mis[r_fq_wr] <= w_fault_push;
        end
    end

    assign bus.fetch_misaligned = w_fetch_valid & r_fq_mis[r_fq_rd];
`else
    assign w_redir_pc           = bus.redirect_pc & 32'hFFFF_FFFC;
    assign w_halt               = 1'b0;
    assign w_fault_push         = 1'b0;
    assign bus.fetch_misaligned = 1'b0;
`endif

    // PC, request/response bookkeeping and FIFO occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_pc    <= RESET_PC;
            r_outst <= {CW{1'b0}};
            r_drop  <= {CW{1'b0}};
            r_count <= {CW{1'b0}};
            r_fq_wr <= {AW{1'b0}};
            r_fq_rd <= {AW{1'b0}};
        end else begin
            r_run   <= 1'b1;
            r_outst <= w_outst_nx;
            r_drop  <= w_drop_nx;
            if (w_redir) begin
                r_pc    <= w_redir_pc;
                r_count <= {CW{1'b0}};
                r_fq_wr <= {AW{1'b0}};
                r_fq_rd <= {AW{1'b0}};
            end else begin
                if (w_req_acc) r_pc <= r_pc + 32'd4;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_push) r_fq_wr <= r_fq_wr + AW'(1'b1);
                if (w_pop)  r_fq_rd <= r_fq_rd + AW'(1'b1);
            end
        end
    end

    // In-flight PC queue: survives redirects so dropped responses stay paired with their requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifq_wr <= {AW{1'b0}};
            r_ifq_rd <= {AW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) r_ifq_pc[i] <= 32'h0000_0000;
        end else begin
            if (w_req_acc) begin
                r_ifq_pc[r_ifq_wr] <= r_pc;
                r_ifq_wr           <= r_ifq_wr + AW'(1'b1);
            end
            if (w_rsp) r_ifq_rd <= r_ifq_rd + AW'(1'b1);
        end
    end

    // Instruction FIFO payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fq_instr[i] <= 32'h0000_0000;
                r_fq_pc[i]    <= 32'h0000_0000;
            end
        end else if (w_push && !w_redir) begin
            r_fq_instr[r_fq_wr] <= w_push_instr;
            r_fq_pc[r_fq_wr]    <= w_push_pc;
        end
    end

    assign bus.imem_req_valid    = w_req_valid;
    assign bus.imem_req_addr     = r_pc;
    assign bus.fetch_valid       = w_fetch_valid;
    assign bus.fetch_instruction = w_fetch_valid ? r_fq_instr[r_fq_rd] : 32'h0000_0000;
    assign bus.fetch_pc          = w_fetch_valid ? r_fq_pc[r_fq_rd]    : 32'h0000_0000;
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Randomized bench for rv32i_fetch_unit: transaction-level model of the fetched PC stream and memory.
module tb_rv32i_fetch_unit;
    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32i_fetch_unit_if bus ();

    rv32i_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_pop = 0;
    int          n_fault = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    logic [31:0] rsp_addr_q [$];
    int          rsp_due_q  [$];
    logic [31:0] m_exp_pc = 32'h0;
    logic [31:0] m_exp_req = 32'h0;
    bit          m_halted = 1'b0;
    bit          m_fault_exp = 1'b0;
    bit          prev_hold = 1'b0;
    bit          prev_req_wait = 1'b0;
    logic [31:0] prev_pc, prev_instr, prev_addr;
    bit          snap_req_valid, snap_fetch_valid;
    bit          want_first = 1'b0;
    logic [31:0] first_pc = 32'hDEAD_BEEF;
    bit          seen_wrap = 1'b0;

    // Instruction memory contents: a simple distinct word per address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a ^ 32'h5A5A_0F0F) + 32'h0101_0101;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock cycle: drive inputs at negedge, sample after settling, update the model.
    task automatic cycle(input bit mrdy, input bit drdy, input bit redir, input logic [31:0] rpc);
        int lat;
        int due;
        @(negedge clk);
        cyc++;
        bus.imem_req_ready = mrdy;
        bus.decode_ready   = drdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memf(rsp_addr_q.pop_front());
            void'(rsp_due_q.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        #1;
        snap_req_valid   = bus.imem_req_valid;
        snap_fetch_valid = bus.fetch_valid;

        if (prev_hold) begin
            check("hold_valid", {31'b0, bus.fetch_valid}, 32'h1);
            check("hold_pc", bus.fetch_pc, prev_pc);
            check("hold_instr", bus.fetch_instruction, prev_instr);
        end
        if (prev_req_wait && !redir) begin
            check("req_hold_valid", {31'b0, bus.imem_req_valid}, 32'h1);
            check("req_hold_addr", bus.imem_req_addr, prev_addr);
        end

        if (bus.fetch_valid) begin
            if (drdy) begin
                n_pop++;
                if (want_first) begin
                    first_pc   = bus.fetch_pc;
                    want_first = 1'b0;
                end
                if (m_fault_exp) begin
                    check("fault_pc", bus.fetch_pc, m_exp_pc);
                    check("fault_instr", bus.fetch_instruction, 32'h0000_0013);
                    check("fault_flag", {31'b0, bus.fetch_misaligned}, 32'h1);
                    m_fault_exp = 1'b0;
                    n_fault++;
                end else if (m_halted) begin
                    check("halt_pop", {31'b0, bus.fetch_valid}, 32'h0);
                end else begin
                    check("pop_pc", bus.fetch_pc, m_exp_pc);
                    check("pop_instr", bus.fetch_instruction, memf(m_exp_pc));
                    check("pop_mis", {31'b0, bus.fetch_misaligned}, 32'h0);
                    m_exp_pc = bus.fetch_pc + 32'd4;
                end
            end
        end else begin
            check("empty_instr", bus.fetch_instruction, 32'h0);
            check("empty_pc", bus.fetch_pc, 32'h0);
            check("empty_mis", {31'b0, bus.fetch_misaligned}, 32'h0);
        end

        if (m_halted) check("halt_noreq", {31'b0, bus.imem_req_valid}, 32'h0);
        if (bus.imem_req_valid && mrdy) begin
            check("req_addr", bus.imem_req_addr, m_exp_req);
            if (bus.imem_req_addr == 32'h0 && m_exp_req == 32'h0) seen_wrap = 1'b1;
            m_exp_req = bus.imem_req_addr + 32'd4;
            lat = int'($urandom_range(lat_hi, lat_lo));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rsp_addr_q.push_back(bus.imem_req_addr);
            rsp_due_q.push_back(due);
        end
        check("credit", {31'b0, (rsp_addr_q.size() <= DEPTH)}, 32'h1);

        prev_hold     = bus.fetch_valid && !drdy && !redir;
        prev_pc       = bus.fetch_pc;
        prev_instr    = bus.fetch_instruction;
        prev_req_wait = bus.imem_req_valid && !mrdy;
        prev_addr     = bus.imem_req_addr;

        if (redir) begin
            check("redir_noreq", {31'b0, bus.imem_req_valid}, 32'h0);
`ifdef RV32I_FETCH_ALIGN_CHECK_EN
            m_halted    = (rpc[1:0] != 2'b00);
            m_fault_exp = m_halted;
            m_exp_pc    = rpc;
            m_exp_req   = rpc;
`else
            m_exp_pc    = rpc & 32'hFFFF_FFFC;
            m_exp_req   = m_exp_pc;
`endif
        end
    endtask

    initial begin
        int p0;
        int inflight;
        logic [31:0] rpc;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.decode_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        check("rst_req_addr", bus.imem_req_addr, 32'h0000_0000);
        check("rst_fetch_valid", {31'b0, bus.fetch_valid}, 32'h0);
        check("rst_instr", bus.fetch_instruction, 32'h0);
        check("rst_pc", bus.fetch_pc, 32'h0);
        check("rst_mis", {31'b0, bus.fetch_misaligned}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch from reset
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("first_req_valid", {31'b0, snap_req_valid}, 32'h1);
        repeat (11) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("t1_pops", {31'b0, (n_pop >= 3)}, 32'h1);

        // Decode stall fills exactly DEPTH entries
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t2_req_stalled", {31'b0, snap_req_valid}, 32'h0);
        check("t2_fetch_valid", {31'b0, snap_fetch_valid}, 32'h1);
        p0 = n_pop;
        repeat (5) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("t2_buffered", n_pop - p0, DEPTH);

        // Redirect with DEPTH requests in flight
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 20; i++) begin
            if (rsp_addr_q.size() == DEPTH) break;
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
        end
        inflight = rsp_addr_q.size();
        check("t3_inflight", inflight, DEPTH);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        want_first = 1'b1;
        repeat (15) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("t3_first_pc", first_pc, 32'h0000_0100);

        // Redirect in the same cycle as a head pop of a full FIFO
        lat_lo = 1; lat_hi = 1;
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        check("t4_pop_in_redir", {31'b0, snap_fetch_valid}, 32'h1);
        want_first = 1'b1;
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("t4_first_pc", first_pc, 32'h0000_0200);

        // PC wrap at the top of the address space
        lat_lo = 1; lat_hi = 2;
        seen_wrap = 1'b0;
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (15) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("t5_wrap", {31'b0, seen_wrap}, 32'h1);

        // Misaligned redirect target
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        want_first = 1'b1;
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef RV32I_FETCH_ALIGN_CHECK_EN
        check("t6_fault_seen", n_fault, 1);
        check("t6_first_pc", first_pc, 32'h0000_0102);
`else
        check("t6_first_pc", first_pc, 32'h0000_0100);
`endif
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300);

        // Randomized traffic with redirects
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h0000_000F);
            if ($urandom_range(0, 3) != 0) rpc = rpc & 32'hFFFF_FFFC;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0, rpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
